// File: rtl/sram_pkg.sv
// Shared types and defaults for the asynchronous SRAM controller.
// Byte-lane support is compiled in with SRAM_BYTE_LANE_EN.
package sram_pkg;

  localparam int unsigned ADDR_W_DEF = 18;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned BE_W       = 2;

  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4
  } state_e;

  // True for every state in which the chip is selected.
  function automatic logic is_access(input state_e s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/sram_async_ctrl.sv
// Two-cycle read/write sequencer for a 256K x 16 asynchronous SRAM.
// Optional byte-lane enables when SRAM_BYTE_LANE_EN is defined.
module sram_async_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_f2s,
`ifdef SRAM_BYTE_LANE_EN
  input  logic [BE_W-1:0]   byte_en,
`endif
  output logic              ready,
  output logic [DATA_W-1:0] data_s2f_r,
  output logic [DATA_W-1:0] data_s2f_ur,
  output logic [ADDR_W-1:0] ad,
  output logic              we_n,
  output logic              oe_n,
  output logic              ce_a_n,
  output logic              ub_a_n,
  output logic              lb_a_n,
  inout  wire  [DATA_W-1:0] dio_a
);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr_q, w_addr_nxt;
  logic [DATA_W-1:0] r_data_q, w_data_nxt;
  logic [DATA_W-1:0] r_rdata,  w_rdata_nxt;
  logic              r_we_n, w_we_n_nxt;
  logic              r_oe_n, w_oe_n_nxt;
  logic              r_ce_n, w_ce_n_nxt;
  logic              r_tri_en, w_tri_en_nxt;

  // Next-state decode; pin strobes are derived from the next state so they
  // are registered and change only on clock edges.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr_q;
    w_data_nxt   = r_data_q;
    w_rdata_nxt  = r_rdata;
    w_we_n_nxt   = 1'b1;
    w_oe_n_nxt   = 1'b1;
    w_ce_n_nxt   = 1'b1;
    w_tri_en_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (mem) begin
          w_addr_nxt  = addr;
          w_data_nxt  = data_f2s;
          w_state_nxt = rw ? RD1 : WR1;
        end
      end
      RD1: w_state_nxt = RD2;
      RD2: begin
        w_rdata_nxt = dio_a;
        w_state_nxt = IDLE;
      end
      WR1: w_state_nxt = WR2;
      WR2: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    unique case (w_state_nxt)
      RD1, RD2: begin
        w_ce_n_nxt = 1'b0;
        w_oe_n_nxt = 1'b0;
      end
      WR1: begin
        w_ce_n_nxt   = 1'b0;
        w_we_n_nxt   = 1'b0;
        w_tri_en_nxt = 1'b1;
      end
      WR2: begin
        w_ce_n_nxt   = 1'b0;
        w_tri_en_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_addr_q <= '0;
      r_data_q <= '0;
      r_rdata  <= '0;
      r_we_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_ce_n   <= 1'b1;
      r_tri_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr_q <= w_addr_nxt;
      r_data_q <= w_data_nxt;
      r_rdata  <= w_rdata_nxt;
      r_we_n   <= w_we_n_nxt;
      r_oe_n   <= w_oe_n_nxt;
      r_ce_n   <= w_ce_n_nxt;
      r_tri_en <= w_tri_en_nxt;
    end
  end

`ifdef SRAM_BYTE_LANE_EN
  logic [BE_W-1:0] r_be_q, w_be_nxt;
  logic            r_ub_n, r_lb_n;
  logic            w_ub_n_nxt, w_lb_n_nxt;

  // Lane enables follow the latched byte_en only while the chip is selected.
  always_comb begin
    w_be_nxt   = r_be_q;
    w_ub_n_nxt = 1'b1;
    w_lb_n_nxt = 1'b1;
    if (r_state == IDLE && mem) begin
      w_be_nxt = byte_en;
    end
    if (is_access(w_state_nxt)) begin
      w_ub_n_nxt = ~w_be_nxt[1];
      w_lb_n_nxt = ~w_be_nxt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_be_q <= '0;
      r_ub_n <= 1'b1;
      r_lb_n <= 1'b1;
    end else begin
      r_be_q <= w_be_nxt;
      r_ub_n <= w_ub_n_nxt;
      r_lb_n <= w_lb_n_nxt;
    end
  end

  assign ub_a_n = r_ub_n;
  assign lb_a_n = r_lb_n;
`else
  assign ub_a_n = 1'b0;
  assign lb_a_n = 1'b0;
`endif

  assign ready       = (r_state == IDLE);
  assign ad          = r_addr_q;
  assign we_n        = r_we_n;
  assign oe_n        = r_oe_n;
  assign ce_a_n      = r_ce_n;
  assign data_s2f_r  = r_rdata;
  assign data_s2f_ur = dio_a;
  assign dio_a       = r_tri_en ? r_data_q : 'z;

endmodule
